// File: rtl/pixel_compositor_pkg.sv
// -----------------------------------------------------------------------------
// pixel_compositor_pkg
// Shared constants and types for the pixel compositor slice.
//   KEY_COLOR  : colour-key value meaning "transparent" in sprite ROMs
//   LANE_W     : width of one lane in pixels (8 lanes across the screen)
//   FARMER_Y   : first row of the farmer band
//   H_VISIBLE / V_VISIBLE : visible raster size
//   layer_e    : layer identifiers used by the compose stage
//   rgb12_t    : 4:4:4 pixel
//   hits_t     : per-sprite-layer hit bits carried down the sideband
//   flash_state_e : penalty-flash FSM states
//   lane_of()  : constant compare chain replacing h_cnt / LANE_W
// -----------------------------------------------------------------------------
package pixel_compositor_pkg;

    localparam logic [11:0] KEY_COLOR = 12'h0F0;
    localparam int          LANE_W    = 80;
    localparam int          FARMER_Y  = 400;
    localparam int          H_VISIBLE = 640;
    localparam int          V_VISIBLE = 480;
    localparam int          NUM_LANES = 8;

    // Lane code returned when the column lies outside every lane.
    localparam logic [3:0]  NO_LANE   = 4'd8;

    typedef enum logic [2:0] {
        LAYER_BG,
        LAYER_BUG,
        LAYER_FARMER,
        LAYER_GREEN,
        LAYER_ORANGE,
        LAYER_YELLOW
    } layer_e;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    typedef struct packed {
        logic farmer;
        logic bug;
        logic green;
        logic orange;
        logic yellow;
    } hits_t;

    typedef enum logic {
        FL_IDLE,
        FL_FLASH
    } flash_state_e;

    // Lane index of column h: the highest lane whose left boundary is <= h.
    // Columns at or beyond the last lane edge (or the visible width) get NO_LANE.
    function automatic logic [3:0] lane_of(input logic [9:0] h, input int lane_w);
        logic [3:0] lane;
        lane = NO_LANE;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (int'(h) >= i * lane_w)
                lane = i[3:0];
        end
        if (int'(h) >= NUM_LANES * lane_w || int'(h) >= H_VISIBLE)
            lane = NO_LANE;
        return lane;
    endfunction

endpackage

// File: rtl/pixel_compositor_pipe_delay.sv
// -----------------------------------------------------------------------------
// pipe_delay
// Fixed-depth register shift line with a synchronous reset value.
//   clk, rst : pixel clock, synchronous active-high reset
//   d        : WIDTH-bit input
//   q        : d delayed by DEPTH clocks (RESET_VAL while the line refills)
// -----------------------------------------------------------------------------
module pipe_delay #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    // NOTE: every stage is reset here (unlike a RAM) because downstream logic
    // treats the reset value as "no pixel / syncs inactive" while refilling.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                stage[i] <= RESET_VAL;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++)
                stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/pixel_compositor.sv
// -----------------------------------------------------------------------------
// pixel_compositor
// Registers per-layer ROM addresses, composites the returned sprite/background
// pixels by fixed priority (farmer > bug > green > orange > yellow > bg) with
// colour-key transparency, and outputs VGA colour with aligned syncs.
// A red "penalty flash" tints the picture for FLASH_FRAMES frames whenever
// score_neg changes.
//   clk, rst            : pixel clock, synchronous active-high reset
//   valid_in            : current pixel is inside the visible area
//   hsync_in, vsync_in  : raw syncs (active low)
//   h_cnt, v_cnt        : current pixel coordinates
//   pixel_addr_*        : per-layer ROM addresses from the address generator
//   show_*, *_x         : sprite layer enables and lane indices
//   score_neg           : penalty score; any change triggers the flash
//   rom_addr_*          : registered ROM addresses
//   rom_data_*          : ROM data, ROM_LAT cycles after rom_addr_*
//   vga_r/g/b, hsync, vsync : output, ROM_LAT + 2 cycles after the inputs
// -----------------------------------------------------------------------------
module pixel_compositor #(
    parameter int          ROM_LAT      = 1,
    parameter logic [11:0] KEY_COLOR    = pixel_compositor_pkg::KEY_COLOR,
    parameter int          LANE_W       = pixel_compositor_pkg::LANE_W,
    parameter int          FARMER_Y     = pixel_compositor_pkg::FARMER_Y,
    parameter int          FLASH_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic [16:0] pixel_addr_bg,
    input  logic [16:0] pixel_addr_bug,
    input  logic [16:0] pixel_addr_farmer,
    input  logic [16:0] pixel_addr_green,
    input  logic [16:0] pixel_addr_orange,
    input  logic [16:0] pixel_addr_yellow,
    input  logic        show_bug,
    input  logic        show_farmer,
    input  logic        show_green,
    input  logic        show_orange,
    input  logic        show_yellow,
    input  logic [2:0]  bug_x,
    input  logic [2:0]  farmer_x,
    input  logic [2:0]  green_x,
    input  logic [2:0]  orange_x,
    input  logic [2:0]  yellow_x,
    input  logic [5:0]  score_neg,
    output logic [16:0] rom_addr_bg,
    output logic [16:0] rom_addr_bug,
    output logic [16:0] rom_addr_farmer,
    output logic [16:0] rom_addr_green,
    output logic [16:0] rom_addr_orange,
    output logic [16:0] rom_addr_yellow,
    input  logic [11:0] rom_data_bg,
    input  logic [11:0] rom_data_bug,
    input  logic [11:0] rom_data_farmer,
    input  logic [11:0] rom_data_green,
    input  logic [11:0] rom_data_orange,
    input  logic [11:0] rom_data_yellow,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync
);

    import pixel_compositor_pkg::*;

    localparam int SB_W  = 3 + $bits(hits_t);
    localparam int CNT_W = $clog2(FLASH_FRAMES + 1);

    // ---------------- Stage S0: addresses and sideband ----------------
    logic [3:0] lane;
    hits_t      hits_d;

    always_comb begin
        lane   = lane_of(h_cnt, LANE_W);
        // NOTE: every always_comb output gets a default first so no latch is
        // inferred on any path.
        hits_d        = '0;
        hits_d.bug    = show_bug    && (lane == {1'b0, bug_x});
        hits_d.farmer = show_farmer && (lane == {1'b0, farmer_x})
                        && (int'(v_cnt) >= FARMER_Y);
        hits_d.green  = show_green  && (lane == {1'b0, green_x});
        hits_d.orange = show_orange && (lane == {1'b0, orange_x});
        hits_d.yellow = show_yellow && (lane == {1'b0, yellow_x});
    end

    logic  s0_valid, s0_hsync, s0_vsync;
    hits_t s0_hits;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr_bg     <= '0;
            rom_addr_bug    <= '0;
            rom_addr_farmer <= '0;
            rom_addr_green  <= '0;
            rom_addr_orange <= '0;
            rom_addr_yellow <= '0;
            s0_valid        <= 1'b0;
            s0_hsync        <= 1'b1;
            s0_vsync        <= 1'b1;
            s0_hits         <= '0;
        end else begin
            rom_addr_bg     <= pixel_addr_bg;
            rom_addr_bug    <= pixel_addr_bug;
            rom_addr_farmer <= pixel_addr_farmer;
            rom_addr_green  <= pixel_addr_green;
            rom_addr_orange <= pixel_addr_orange;
            rom_addr_yellow <= pixel_addr_yellow;
            s0_valid        <= valid_in;
            s0_hsync        <= hsync_in;
            s0_vsync        <= vsync_in;
            s0_hits         <= hits_d;
        end
    end

    // ---------------- Stages S1..S_ROM_LAT: align sideband with ROM data ----------------
    logic [SB_W-1:0] sb_q;
    logic            d_valid, d_hsync, d_vsync;
    hits_t           d_hits;

    pipe_delay #(
        .WIDTH     (SB_W),
        .DEPTH     (ROM_LAT),
        .RESET_VAL ({1'b0, 1'b1, 1'b1, {$bits(hits_t){1'b0}}})
    ) u_sideband (
        .clk (clk),
        .rst (rst),
        .d   ({s0_valid, s0_hsync, s0_vsync, s0_hits}),
        .q   (sb_q)
    );

    assign {d_valid, d_hsync, d_vsync, d_hits} = sb_q;

    // ---------------- Penalty flash FSM ----------------
    logic         vsync_prev;
    logic         vsync_fall;
    logic         primed;
    logic [5:0]   score_prev;
    logic         score_change;
    logic [CNT_W-1:0] flash_cnt;
    flash_state_e flash_state;

    pipe_delay #(
        .WIDTH     (1),
        .DEPTH     (1),
        .RESET_VAL (1'b1)
    ) u_vsync_prev (
        .clk (clk),
        .rst (rst),
        .d   (vsync_in),
        .q   (vsync_prev)
    );

    assign vsync_fall   = vsync_prev && !vsync_in;
    // score_prev is meaningless until one post-reset sample has been taken.
    assign score_change = primed && (score_neg != score_prev);

    always_ff @(posedge clk) begin
        if (rst) begin
            flash_state <= FL_IDLE;
            flash_cnt   <= '0;
            score_prev  <= '0;
            primed      <= 1'b0;
        end else begin
            primed     <= 1'b1;
            score_prev <= score_neg;
            // A change wins over a simultaneous vsync edge: reload, not decrement.
            if (score_change) begin
                flash_state <= FL_FLASH;
                flash_cnt   <= CNT_W'(FLASH_FRAMES);
            end else if (flash_state == FL_FLASH && vsync_fall) begin
                if (flash_cnt <= CNT_W'(1)) begin
                    flash_cnt   <= '0;
                    flash_state <= FL_IDLE;
                end else begin
                    flash_cnt <= flash_cnt - CNT_W'(1);
                end
            end
        end
    end

    // ---------------- Compose stage ----------------
    layer_e win;
    rgb12_t pix;
    rgb12_t out_px;

    always_comb begin
        // Later assignments override earlier ones, so the list runs from
        // lowest to highest priority.
        win = LAYER_BG;
        if (d_hits.yellow && rom_data_yellow != KEY_COLOR) win = LAYER_YELLOW;
        if (d_hits.orange && rom_data_orange != KEY_COLOR) win = LAYER_ORANGE;
        if (d_hits.green  && rom_data_green  != KEY_COLOR) win = LAYER_GREEN;
        if (d_hits.bug    && rom_data_bug    != KEY_COLOR) win = LAYER_BUG;
        if (d_hits.farmer && rom_data_farmer != KEY_COLOR) win = LAYER_FARMER;

        case (win)
            LAYER_FARMER: pix = rom_data_farmer;
            LAYER_BUG:    pix = rom_data_bug;
            LAYER_GREEN:  pix = rom_data_green;
            LAYER_ORANGE: pix = rom_data_orange;
            LAYER_YELLOW: pix = rom_data_yellow;
            default:      pix = rom_data_bg;
        endcase

        out_px = pix;
        if (flash_state == FL_FLASH)
            out_px = '{r: 4'hF, g: pix.g >> 1, b: pix.b >> 1};
        if (!d_valid)
            out_px = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            vga_r <= out_px.r;
            vga_g <= out_px.g;
            vga_b <= out_px.b;
            hsync <= d_hsync;
            vsync <= d_vsync;
        end
    end

endmodule

// File: tb/tb_pixel_compositor.sv
// -----------------------------------------------------------------------------
// tb_pixel_compositor
// Directed bench for pixel_compositor. The ROMs are modelled as registered
// lookups (one cycle latency): the background ROM returns addr[11:0], sprite
// ROMs return KEY_COLOR at address 0 and addr[11:0] elsewhere, so each
// pixel_addr_* value selects the colour that layer contributes.
// -----------------------------------------------------------------------------
module tb_pixel_compositor;

    localparam logic [11:0] KEY = 12'h0F0;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, hsync_in, vsync_in;
    logic [9:0]  h_cnt, v_cnt;
    logic [16:0] pixel_addr_bg, pixel_addr_bug, pixel_addr_farmer;
    logic [16:0] pixel_addr_green, pixel_addr_orange, pixel_addr_yellow;
    logic        show_bug, show_farmer, show_green, show_orange, show_yellow;
    logic [2:0]  bug_x, farmer_x, green_x, orange_x, yellow_x;
    logic [5:0]  score_neg;
    logic [16:0] rom_addr_bg, rom_addr_bug, rom_addr_farmer;
    logic [16:0] rom_addr_green, rom_addr_orange, rom_addr_yellow;
    logic [11:0] rom_data_bg, rom_data_bug, rom_data_farmer;
    logic [11:0] rom_data_green, rom_data_orange, rom_data_yellow;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        hsync, vsync;

    int checks   = 0;
    int failures = 0;

    pixel_compositor dut (
        .clk               (clk),
        .rst               (rst),
        .valid_in          (valid_in),
        .hsync_in          (hsync_in),
        .vsync_in          (vsync_in),
        .h_cnt             (h_cnt),
        .v_cnt             (v_cnt),
        .pixel_addr_bg     (pixel_addr_bg),
        .pixel_addr_bug    (pixel_addr_bug),
        .pixel_addr_farmer (pixel_addr_farmer),
        .pixel_addr_green  (pixel_addr_green),
        .pixel_addr_orange (pixel_addr_orange),
        .pixel_addr_yellow (pixel_addr_yellow),
        .show_bug          (show_bug),
        .show_farmer       (show_farmer),
        .show_green        (show_green),
        .show_orange       (show_orange),
        .show_yellow       (show_yellow),
        .bug_x             (bug_x),
        .farmer_x          (farmer_x),
        .green_x           (green_x),
        .orange_x          (orange_x),
        .yellow_x          (yellow_x),
        .score_neg         (score_neg),
        .rom_addr_bg       (rom_addr_bg),
        .rom_addr_bug      (rom_addr_bug),
        .rom_addr_farmer   (rom_addr_farmer),
        .rom_addr_green    (rom_addr_green),
        .rom_addr_orange   (rom_addr_orange),
        .rom_addr_yellow   (rom_addr_yellow),
        .rom_data_bg       (rom_data_bg),
        .rom_data_bug      (rom_data_bug),
        .rom_data_farmer   (rom_data_farmer),
        .rom_data_green    (rom_data_green),
        .rom_data_orange   (rom_data_orange),
        .rom_data_yellow   (rom_data_yellow),
        .vga_r             (vga_r),
        .vga_g             (vga_g),
        .vga_b             (vga_b),
        .hsync             (hsync),
        .vsync             (vsync)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] sprite_rom(input logic [16:0] a);
        return (a == 17'd0) ? KEY : a[11:0];
    endfunction

    always @(posedge clk) begin
        rom_data_bg     <= rom_addr_bg[11:0];
        rom_data_bug    <= sprite_rom(rom_addr_bug);
        rom_data_farmer <= sprite_rom(rom_addr_farmer);
        rom_data_green  <= sprite_rom(rom_addr_green);
        rom_data_orange <= sprite_rom(rom_addr_orange);
        rom_data_yellow <= sprite_rom(rom_addr_yellow);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait the full pipeline latency, then compare the output colour.
    task automatic expect_px(input string tag, input logic [11:0] exp);
        repeat (3) tick();
        check(tag, {20'd0, vga_r, vga_g, vga_b}, {20'd0, exp});
    endtask

    task automatic vsync_edge();
        vsync_in = 1'b0;
        tick();
        vsync_in = 1'b1;
        tick();
    endtask

    task automatic hide_all();
        show_bug = 0; show_farmer = 0; show_green = 0; show_orange = 0; show_yellow = 0;
        pixel_addr_bug = '0; pixel_addr_farmer = '0; pixel_addr_green = '0;
        pixel_addr_orange = '0; pixel_addr_yellow = '0;
    endtask

    initial begin
        // ---------------- Reset with random inputs ----------------
        rst = 1'b1;
        score_neg = 6'd5;
        for (int i = 0; i < 3; i++) begin
            valid_in = 1'($urandom); hsync_in = 1'($urandom); vsync_in = 1'($urandom);
            h_cnt = 10'($urandom); v_cnt = 10'($urandom);
            pixel_addr_bg = 17'($urandom); pixel_addr_bug = 17'($urandom);
            pixel_addr_farmer = 17'($urandom); pixel_addr_green = 17'($urandom);
            pixel_addr_orange = 17'($urandom); pixel_addr_yellow = 17'($urandom);
            show_bug = 1'($urandom); show_farmer = 1'($urandom); show_green = 1'($urandom);
            show_orange = 1'($urandom); show_yellow = 1'($urandom);
            bug_x = 3'($urandom); farmer_x = 3'($urandom); green_x = 3'($urandom);
            orange_x = 3'($urandom); yellow_x = 3'($urandom);
            tick();
            check("rst_rgb", {20'd0, vga_r, vga_g, vga_b}, 32'd0);
            check("rst_syncs", {30'd0, hsync, vsync}, 32'd3);
            check("rst_addr", {15'd0, rom_addr_bg | rom_addr_bug | rom_addr_farmer
                                      | rom_addr_green | rom_addr_orange | rom_addr_yellow}, 32'd0);
        end

        // ---------------- Background only, latency 3; score 5 held (no first-cycle flash) ----------------
        rst = 1'b0;
        hide_all();
        valid_in = 1; hsync_in = 0; vsync_in = 0;
        h_cnt = 10'd100; v_cnt = 10'd100;
        pixel_addr_bg = 17'h00123;
        bug_x = 0; farmer_x = 0; green_x = 0; orange_x = 0; yellow_x = 0;
        repeat (2) tick();
        check("lat2_rgb", {20'd0, vga_r, vga_g, vga_b}, 32'd0);
        check("lat2_syncs", {30'd0, hsync, vsync}, 32'd3);
        tick();
        check("lat3_rgb", {20'd0, vga_r, vga_g, vga_b}, 32'h123);
        check("lat3_syncs", {30'd0, hsync, vsync}, 32'd0);
        hsync_in = 1; vsync_in = 1;
        expect_px("no_first_flash", 12'h123);

        // ---------------- Priority ----------------
        h_cnt = 10'd40; v_cnt = 10'd420;
        pixel_addr_bg = 17'h00321;
        show_farmer = 1; show_bug = 1;
        pixel_addr_farmer = 17'h00A50; pixel_addr_bug = 17'h0000F;
        expect_px("farmer_over_bug", 12'hA50);
        pixel_addr_farmer = 17'h000F0;
        expect_px("farmer_key", 12'h00F);
        pixel_addr_farmer = 17'h00A50;
        v_cnt = 10'd399;
        expect_px("farmer_band_399", 12'h00F);
        v_cnt = 10'd400;
        expect_px("farmer_band_400", 12'hA50);

        // ---------------- Transparency and lane ----------------
        show_farmer = 0;
        pixel_addr_bug = 17'h000F0;
        expect_px("bug_key", 12'h321);
        pixel_addr_bug = 17'h0000F;
        h_cnt = 10'd79;
        expect_px("lane0_79", 12'h00F);
        h_cnt = 10'd80;
        expect_px("lane0_80", 12'h321);

        // ---------------- Lower layers ----------------
        hide_all();
        h_cnt = 10'd200;
        show_green = 1; show_orange = 1; show_yellow = 1;
        green_x = 2; orange_x = 2; yellow_x = 2;
        pixel_addr_green = 17'h000C1; pixel_addr_orange = 17'h008A0; pixel_addr_yellow = 17'h00777;
        expect_px("green_top", 12'h0C1);
        show_green = 0;
        expect_px("orange_top", 12'h8A0);
        pixel_addr_orange = 17'h0;
        expect_px("orange_addr0", 12'h777);
        h_cnt = 10'd639; yellow_x = 7;
        expect_px("lane7_639", 12'h777);
        yellow_x = 6;
        expect_px("lane6_miss", 12'h321);

        // ---------------- Blanking ----------------
        yellow_x = 7;
        valid_in = 0; hsync_in = 0;
        expect_px("blank_rgb", 12'h000);
        check("blank_hsync", {31'd0, hsync}, 32'd0);
        valid_in = 1; hsync_in = 1;
        hide_all();
        pixel_addr_bg = 17'h000A8;
        expect_px("plain_0a8", 12'h0A8);

        // ---------------- Mid-frame reset, then score 0 ----------------
        rst = 1; score_neg = 6'd0;
        tick();
        check("mid_rst_rgb", {20'd0, vga_r, vga_g, vga_b}, 32'd0);
        check("mid_rst_addr", {15'd0, rom_addr_bg}, 32'd0);
        rst = 0;
        repeat (2) tick();
        check("refill2", {20'd0, vga_r, vga_g, vga_b}, 32'd0);
        tick();
        check("refill3", {20'd0, vga_r, vga_g, vga_b}, 32'h0A8);

        // ---------------- Flash: 8 frames ----------------
        score_neg = 6'd3;
        tick();
        expect_px("flash_on", 12'hF54);
        for (int i = 0; i < 7; i++) vsync_edge();
        expect_px("flash_7_edges", 12'hF54);
        vsync_edge();
        expect_px("flash_8_edges", 12'h0A8);

        // ---------------- Flash extended by second change after 4 edges ----------------
        score_neg = 6'd4;
        tick();
        for (int i = 0; i < 4; i++) vsync_edge();
        score_neg = 6'd7;
        tick();
        for (int i = 0; i < 7; i++) vsync_edge();
        expect_px("ext_11_edges", 12'hF54);
        vsync_edge();
        expect_px("ext_12_edges", 12'h0A8);

        // ---------------- Change and vsync edge together: reload wins ----------------
        score_neg = 6'd9;
        tick();
        vsync_edge();
        score_neg = 6'd10;
        vsync_in = 0;
        tick();
        vsync_in = 1;
        tick();
        for (int i = 0; i < 7; i++) vsync_edge();
        expect_px("reload_7_edges", 12'hF54);
        vsync_edge();
        expect_px("reload_8_edges", 12'h0A8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
